light_mode_ctrl: RTL and testbench

Sequencing controller for the bicycle rear light. Turns the `faster`, `slower` and `next` button levels into a registered light mode plus two saturating blink-rate registers, one per blinker. It also issues a one-cycle configuration strobe. It sits between the raw button inputs and the blinker/mux datapath, and is paced by the `beat32` tick for hold-to-repeat timing.

---
 rtl/light_mode_ctrl_pkg.sv | 29 ++
 rtl/light_mode_ctrl_button_press.sv | 68 ++++++
 rtl/light_mode_ctrl.sv | 101 ++++++++++
 tb/tb_light_mode_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/light_mode_ctrl_pkg.sv
// rtl/light_mode_ctrl_pkg.sv - shared mode encodings and rate defaults for the rear-light controller
package light_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_ON   = 2'b01,
    MODE_FAST = 2'b10,
    MODE_SLOW = 2'b11
  } mode_t;

  localparam int RATE_W       = 4;
  localparam int RATE_MIN     = 1;
  localparam int RATE_MAX     = 15;
  localparam int FAST_INIT    = 4;
  localparam int SLOW_INIT    = 8;
  localparam int HOLD_BEATS   = 16;
  localparam int REPEAT_BEATS = 4;

  // Mode sequence stepped by the next button; SLOW wraps back to OFF.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_OFF:  return MODE_ON;
      MODE_ON:   return MODE_FAST;
      MODE_FAST: return MODE_SLOW;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/light_mode_ctrl_button_press.sv
// rtl/light_mode_ctrl_button_press.sv - button edge detect with optional hold/repeat (LIGHT_MODE_CTRL_AUTO_REPEAT_EN)
module button_press #(
  parameter bit REPEAT_EN    = 1'b0,
  parameter int HOLD_BEATS   = 16,
  parameter int REPEAT_BEATS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic beat,
  input  logic clear,
  output logic press
);

  logic prev_q;
  logic edge_hit;

  // Previous sample starts at 1 so a button held through reset release does not fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b1;
    else      prev_q <= level;
  end

  assign edge_hit = level & ~prev_q;

`ifdef LIGHT_MODE_CTRL_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int CNT_W = $clog2(HOLD_BEATS + 1);
    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(HOLD_BEATS - 1);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(HOLD_BEATS - REPEAT_BEATS);

    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             synth;

    // Counter reaching FIRE_AT on a beat means this beat completes the hold or repeat interval.
    assign synth = armed_q & level & ~clear & beat & (cnt_q == FIRE_AT);

    // Arm on a real edge, count beats while held, reload after each synthetic press.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (!level || clear) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (edge_hit) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else if (armed_q && beat) begin
        cnt_q <= synth ? RELOAD : cnt_q + 1'b1;
      end
    end

    assign press = edge_hit | synth;
  end else begin : g_norep
    logic unused_rep;
    assign unused_rep = beat ^ clear;
    assign press      = edge_hit;
  end
`else
  localparam int unused_cfg = HOLD_BEATS + REPEAT_BEATS + int'(REPEAT_EN);
  logic unused_rep;
  assign unused_rep = beat ^ clear;
  assign press      = edge_hit;
`endif

endmodule

// File: rtl/light_mode_ctrl.sv
// rtl/light_mode_ctrl.sv - rear-light mode FSM with saturating blink rates (LIGHT_MODE_CTRL_AUTO_REPEAT_EN)
module light_mode_ctrl
  import light_mode_ctrl_pkg::*;
#(
  parameter int RATE_W       = light_mode_ctrl_pkg::RATE_W,
  parameter int RATE_MIN     = light_mode_ctrl_pkg::RATE_MIN,
  parameter int RATE_MAX     = light_mode_ctrl_pkg::RATE_MAX,
  parameter int FAST_INIT    = light_mode_ctrl_pkg::FAST_INIT,
  parameter int SLOW_INIT    = light_mode_ctrl_pkg::SLOW_INIT,
  parameter int HOLD_BEATS   = light_mode_ctrl_pkg::HOLD_BEATS,
  parameter int REPEAT_BEATS = light_mode_ctrl_pkg::REPEAT_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              faster,
  input  logic              slower,
  input  logic              next,
  input  logic              beat,
  output logic [1:0]        mode,
  output logic [RATE_W-1:0] fast_rate,
  output logic [RATE_W-1:0] slow_rate,
  output logic              cfg_strobe
);

`ifdef LIGHT_MODE_CTRL_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam logic [RATE_W-1:0] RMIN  = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] RMAX  = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] FINIT = RATE_W'(FAST_INIT);
  localparam logic [RATE_W-1:0] SINIT = RATE_W'(SLOW_INIT);

  logic next_p;
  logic faster_p;
  logic slower_p;

  mode_t             mode_q, mode_n;
  logic [RATE_W-1:0] fast_q, fast_n;
  logic [RATE_W-1:0] slow_q, slow_n;
  logic              strobe_q, strobe_n;

  // Saturating single step; a step at the limit returns the value unchanged.
  function automatic logic [RATE_W-1:0] step_rate(input logic [RATE_W-1:0] r, input logic up);
    if (up) return (r >= RMAX) ? r : r + 1'b1;
    else    return (r <= RMIN) ? r : r - 1'b1;
  endfunction

  button_press #(.REPEAT_EN(1'b0), .HOLD_BEATS(HOLD_BEATS), .REPEAT_BEATS(REPEAT_BEATS)) u_next (
    .clk(clk), .rst(rst), .level(next), .beat(beat), .clear(1'b0), .press(next_p)
  );

  // A held rate button loses its repeat when the other one is held or the mode changes.
  button_press #(.REPEAT_EN(REP_EN), .HOLD_BEATS(HOLD_BEATS), .REPEAT_BEATS(REPEAT_BEATS)) u_faster (
    .clk(clk), .rst(rst), .level(faster), .beat(beat), .clear(slower | next_p), .press(faster_p)
  );

  button_press #(.REPEAT_EN(REP_EN), .HOLD_BEATS(HOLD_BEATS), .REPEAT_BEATS(REPEAT_BEATS)) u_slower (
    .clk(clk), .rst(rst), .level(slower), .beat(beat), .clear(faster | next_p), .press(slower_p)
  );

  // State register: mode, both rates and the change strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_OFF;
      fast_q   <= FINIT;
      slow_q   <= SINIT;
      strobe_q <= 1'b0;
    end else begin
      mode_q   <= mode_n;
      fast_q   <= fast_n;
      slow_q   <= slow_n;
      strobe_q <= strobe_n;
    end
  end

  // Next state: next wins over rate presses, opposing rate presses cancel.
  always_comb begin
    mode_n = mode_q;
    fast_n = fast_q;
    slow_n = slow_q;
    if (next_p) begin
      mode_n = next_mode(mode_q);
    end else if (faster_p ^ slower_p) begin
      if (mode_q == MODE_FAST)      fast_n = step_rate(fast_q, faster_p);
      else if (mode_q == MODE_SLOW) slow_n = step_rate(slow_q, faster_p);
    end
    strobe_n = (mode_n != mode_q) | (fast_n != fast_q) | (slow_n != slow_q);
  end

  // Outputs straight from the registers.
  always_comb begin
    mode       = mode_q;
    fast_rate  = fast_q;
    slow_rate  = slow_q;
    cfg_strobe = strobe_q;
  end

endmodule

// File: tb/tb_light_mode_ctrl.sv
// tb/tb_light_mode_ctrl.sv - directed self-checking bench for light_mode_ctrl
module tb_light_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       faster;
  logic       slower;
  logic       next;
  logic       beat;
  logic [1:0] mode;
  logic [3:0] fast_rate;
  logic [3:0] slow_rate;
  logic       cfg_strobe;

  int n_checks;
  int n_pass;

  light_mode_ctrl dut (
    .clk(clk), .rst(rst), .faster(faster), .slower(slower), .next(next), .beat(beat),
    .mode(mode), .fast_rate(fast_rate), .slow_rate(slow_rate), .cfg_strobe(cfg_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One-cycle level pulse on the chosen buttons; returns at the negedge after the update edge.
  task automatic btn(input logic f, input logic s, input logic n);
    @(posedge clk); #1;
    faster = f; slower = s; next = n;
    @(posedge clk); #1;
    faster = 1'b0; slower = 1'b0; next = 1'b0;
    @(negedge clk);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; beat = 1'b1;
      @(posedge clk); #1; beat = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_r;
    logic [1:0] exp_m;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0; faster = 1'b0; slower = 1'b0; next = 1'b0; beat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mode", mode, 2'd0);
    check("rst_fast", fast_rate, 4'd4);
    check("rst_slow", slow_rate, 4'd8);
    check("rst_strobe", cfg_strobe, 1'b0);
    @(posedge clk); #1; rst = 1'b1;

    // Mode cycle OFF -> ON -> FAST -> SLOW -> OFF
    exp_m = 2'd0;
    for (int i = 0; i < 4; i++) begin
      btn(1'b0, 1'b0, 1'b1);
      exp_m = exp_m + 2'd1;
      check("next_mode", mode, exp_m);
      check("next_strobe", cfg_strobe, 1'b1);
    end
    @(negedge clk);
    check("strobe_one_cycle", cfg_strobe, 1'b0);

    // FAST: 12 faster presses saturate at 15
    btn(1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b0, 1'b1);
    check("in_fast", mode, 2'd2);
    exp_r = 4;
    for (int i = 0; i < 12; i++) begin
      btn(1'b1, 1'b0, 1'b0);
      check("fast_up_strobe", cfg_strobe, (exp_r < 15) ? 1'b1 : 1'b0);
      if (exp_r < 15) exp_r++;
      check("fast_up_rate", fast_rate, exp_r);
    end

    // SLOW: 10 slower presses saturate at 1
    btn(1'b0, 1'b0, 1'b1);
    check("in_slow", mode, 2'd3);
    exp_r = 8;
    for (int i = 0; i < 10; i++) begin
      btn(1'b0, 1'b1, 1'b0);
      check("slow_dn_strobe", cfg_strobe, (exp_r > 1) ? 1'b1 : 1'b0);
      if (exp_r > 1) exp_r--;
      check("slow_dn_rate", slow_rate, exp_r);
    end
    check("fast_kept", fast_rate, 4'd15);

    // OFF/ON ignore rate presses
    btn(1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b1, 1'b0);
    check("off_ignore_fast", fast_rate, 4'd15);
    check("off_ignore_strobe", cfg_strobe, 1'b0);
    btn(1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b1, 1'b0);
    check("on_ignore_fast", fast_rate, 4'd15);
    check("on_ignore_slow", slow_rate, 4'd1);

    // FAST: one step down, then next+faster together
    btn(1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b1, 1'b0);
    check("fast_dn", fast_rate, 4'd14);
    btn(1'b1, 1'b0, 1'b1);
    check("next_wins_mode", mode, 2'd3);
    check("next_wins_fast", fast_rate, 4'd14);

    // SLOW: faster+slower cancel
    btn(1'b1, 1'b1, 1'b0);
    check("cancel_slow", slow_rate, 4'd1);
    check("cancel_mode", mode, 2'd3);
    check("cancel_strobe", cfg_strobe, 1'b0);

    // Full circle keeps both rates
    for (int i = 0; i < 4; i++) btn(1'b0, 1'b0, 1'b1);
    check("circle_mode", mode, 2'd3);
    check("circle_fast", fast_rate, 4'd14);
    check("circle_slow", slow_rate, 4'd1);

    // Hold faster in FAST from a fresh reset
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    btn(1'b0, 1'b0, 1'b1);
    btn(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1; faster = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hold_edge", fast_rate, 4'd5);
    beats(16);
`ifdef LIGHT_MODE_CTRL_AUTO_REPEAT_EN
    check("hold_b16", fast_rate, 4'd6);
    beats(6);
    check("hold_b22", fast_rate, 4'd7);
`else
    check("hold_b16", fast_rate, 4'd5);
    beats(6);
    check("hold_b22", fast_rate, 4'd5);
`endif

    // Reset mid-hold takes effect immediately
    #2 rst = 1'b0;
    #1;
    check("midrst_mode", mode, 2'd0);
    check("midrst_fast", fast_rate, 4'd4);
    check("midrst_slow", slow_rate, 4'd8);
    check("midrst_strobe", cfg_strobe, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    beats(20);
    check("post_rst_fast", fast_rate, 4'd4);
    check("post_rst_strobe", cfg_strobe, 1'b0);
    faster = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
